// File: rtl/jk_bank_pkg.sv
// Shared types and JK excitation helpers for the JK register-bank driver.
// Op encodings, FSM states and per-bit excitation/target functions.
package jk_bank_pkg;

  localparam logic [1:0] OP_LOAD   = 2'd0;
  localparam logic [1:0] OP_SET    = 2'd1;
  localparam logic [1:0] OP_CLR    = 2'd2;
  localparam logic [1:0] OP_TOGGLE = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    EXCITE,
    CHECK
  } state_t;

  // {j, k} for one cell; LOAD don't-cares resolve to 0
  function automatic logic [1:0] jk_excite(
    input logic       q,
    input logic [1:0] op,
    input logic       d
  );
    logic [1:0] jk;
    jk = 2'b00;
    unique case (op)
      OP_LOAD:   jk = {~q & d, q & ~d};
      OP_SET:    jk = {d, 1'b0};
      OP_CLR:    jk = {1'b0, d};
      OP_TOGGLE: jk = {d, d};
      default:   jk = 2'b00;
    endcase
    return jk;
  endfunction

  function automatic logic jk_target(
    input logic       q,
    input logic [1:0] op,
    input logic       d
  );
    logic t;
    t = q;
    unique case (op)
      OP_LOAD:   t = d;
      OP_SET:    t = q | d;
      OP_CLR:    t = q & ~d;
      OP_TOGGLE: t = q ^ d;
      default:   t = q;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/jk_bank_driver_cell.sv
// Single JK flip-flop cell with async active-high clear.
// Exposes its next state so the driver can check the word it is about to hold.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_next
);

  always_comb begin
    q_next = q;
    unique case ({j, k})
      2'b00:   q_next = q;
      2'b01:   q_next = 1'b0;
      2'b10:   q_next = 1'b1;
      2'b11:   q_next = ~q;
      default: q_next = q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= q_next;
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Command-driven front end for a bank of JK cells: FIFO, excite, self-check.
// Each command takes IDLE -> EXCITE -> CHECK; done/match/flips are registered.
module jk_bank_driver
  import jk_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [WIDTH-1:0]             cmd_data,
  output logic [WIDTH-1:0]             j,
  output logic [WIDTH-1:0]             k,
  output logic [WIDTH-1:0]             q,
  output logic [WIDTH-1:0]             qb,
  output logic                         busy,
  output logic                         done,
  output logic                         match,
  output logic [$clog2(WIDTH+1)-1:0]   flips
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int FW = $clog2(WIDTH + 1);

  logic [1:0]       op_mem   [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             push;
  logic             pop;

  state_t           state;
  state_t           state_nxt;

  logic [1:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] q_prev;
  logic [WIDTH-1:0] exp_r;
  logic [WIDTH-1:0] exp_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] diff;
  logic [FW-1:0]    pop_cnt;
  logic [1:0]       head_op;
  logic [WIDTH-1:0] head_data;

  // FIFO: count is registered, so an entry is never popped on its push edge
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign head_op   = op_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  always_comb begin
    count_nxt = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt;
      cmd_ready <= (count_nxt != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]   <= cmd_op;
      data_mem[wr_ptr] <= cmd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (count != '0) state_nxt = EXCITE;
      EXCITE:  state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    exp_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      exp_nxt[i] = jk_target(q[i], head_op, head_data[i]);
    end
  end

  // Cells hold whenever the FSM is not exciting them
  always_comb begin
    j = '0;
    k = '0;
    if (state == EXCITE) begin
      for (int i = 0; i < WIDTH; i++) begin
        {j[i], k[i]} = jk_excite(q[i], op_r, data_r[i]);
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .j      (j[i]),
      .k      (k[i]),
      .q      (q[i]),
      .q_next (q_nxt[i])
    );
  end

  assign qb   = ~q;
  assign busy = (state != IDLE) || (count != '0);
  assign diff = q_nxt ^ q_prev;

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_cnt = pop_cnt + FW'(diff[i]);
    end
  end

  // Result is captured on the edge the cells take their new value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r   <= OP_LOAD;
      data_r <= '0;
      q_prev <= '0;
      exp_r  <= '0;
      done   <= 1'b0;
      match  <= 1'b0;
      flips  <= '0;
    end else begin
      if (pop) begin
        op_r   <= head_op;
        data_r <= head_data;
        q_prev <= q;
        exp_r  <= exp_nxt;
      end
      done <= (state == EXCITE);
      if (state == EXCITE) begin
        match <= (q_nxt == exp_r);
        flips <= pop_cnt;
      end
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Self-checking bench for jk_bank_driver with a queue-based scoreboard.
// Expected words are computed when a command is accepted and checked on done.
module tb_jk_bank_driver;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int FW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'd0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [WIDTH-1:0] j, k, q, qb;
  logic             busy, done, match;
  logic [FW-1:0]    flips;

  typedef struct {
    logic [WIDTH-1:0] exp_q;
    int               exp_flips;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] model_q = '0;
  int               n_cmp = 0;
  int               n_err = 0;
  bit               saw_stall = 0;

  jk_bank_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .j         (j),
    .k         (k),
    .q         (q),
    .qb        (qb),
    .busy      (busy),
    .done      (done),
    .match     (match),
    .flips     (flips)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_next(
    input logic [WIDTH-1:0] cur,
    input logic [1:0]       op,
    input logic [WIDTH-1:0] d
  );
    case (op)
      2'd0:    return d;
      2'd1:    return cur | d;
      2'd2:    return cur & ~d;
      default: return cur ^ d;
    endcase
  endfunction

  // Accepted commands update the reference model in order
  always @(posedge clk) begin
    if (!rst && cmd_valid && cmd_ready) begin
      exp_t e;
      e.exp_q     = ref_next(model_q, cmd_op, cmd_data);
      e.exp_flips = $countones(e.exp_q ^ model_q);
      model_q     = e.exp_q;
      sb.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (!rst && done) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL done_unexpected: done=1 with empty scoreboard");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (q !== e.exp_q || match !== 1'b1 || flips !== FW'(e.exp_flips)) begin
          n_err++;
          $display("FAIL done_result: q=%h match=%b flips=%0d need q=%h match=1 flips=%0d",
                   q, match, flips, e.exp_q, e.exp_flips);
        end
      end
      n_cmp++;
      if (j !== '0 || k !== '0) begin
        n_err++;
        $display("FAIL hold_in_check: j=%h k=%h need 00/00", j, k);
      end
    end
    if (!rst && !busy) begin
      n_cmp++;
      if (j !== '0 || k !== '0 || qb !== ~q) begin
        n_err++;
        $display("FAIL hold_idle: j=%h k=%h qb=%h q=%h", j, k, qb, q);
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] d);
    bit r;
    int c;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    c = 0;
    forever begin
      r = cmd_ready;
      if (!r) saw_stall = 1;
      @(posedge clk);
      if (r) break;
      c++;
      if (c > 50) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: cmd_ready=0 need 1 within 50 cycles");
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((busy || sb.size() != 0) && c < 200) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (c >= 200) begin
      n_err++;
      $display("FAIL idle_timeout: busy=%b pending=%0d need 0/0", busy, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (q !== '0 || qb !== '1 || j !== '0 || k !== '0) begin
      n_err++;
      $display("FAIL reset_cells: q=%h qb=%h j=%h k=%h need 00/ff/00/00", q, qb, j, k);
    end
    n_cmp++;
    if (done !== 1'b0 || match !== 1'b0 || flips !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: done=%b match=%b flips=%0d busy=%b need 0", done, match, flips, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: cmd_ready=%b need 1", cmd_ready);
    end
  endtask

  task automatic test_load();
    send(2'd0, 8'hA5);
    n_cmp++;
    if (j !== '0 || k !== '0 || q !== '0) begin
      n_err++;
      $display("FAIL load_pre: j=%h k=%h q=%h need 00/00/00", j, k, q);
    end
    @(negedge clk);
    n_cmp++;
    if (j !== 8'hA5 || k !== 8'h00) begin
      n_err++;
      $display("FAIL load_excite: j=%h k=%h need a5/00", j, k);
    end
    @(negedge clk);
    n_cmp++;
    if (q !== 8'hA5 || done !== 1'b1 || flips !== FW'(4)) begin
      n_err++;
      $display("FAIL load_latency: q=%h done=%b flips=%0d need a5/1/4", q, done, flips);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int exc;
    logic [WIDTH-1:0] cj, ck;
    exc = 0;
    cj = 'x;
    ck = 'x;
    send(2'd3, 8'hFF);
    send(2'd2, 8'h0F);
    for (int c = 0; c < 12; c++) begin
      if ((j | k) !== '0) begin
        exc++;
        if (exc == 2) begin
          cj = j;
          ck = k;
          break;
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (cj !== 8'h00 || ck !== 8'h0F) begin
      n_err++;
      $display("FAIL b2b_excite: j=%h k=%h need 00/0f", cj, ck);
    end
    wait_idle();
    n_cmp++;
    if (q !== 8'h50) begin
      n_err++;
      $display("FAIL b2b_final: q=%h need 50", q);
    end
  endtask

  task automatic test_full();
    saw_stall = 0;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      send(2'($urandom_range(0, 3)), WIDTH'($urandom));
    end
    n_cmp++;
    if (saw_stall !== 1'b1) begin
      n_err++;
      $display("FAIL full_stall: cmd_ready never dropped, saw=%b need 1", saw_stall);
    end
    wait_idle();
    n_cmp++;
    if (q !== model_q) begin
      n_err++;
      $display("FAIL full_final: q=%h need %h", q, model_q);
    end
  endtask

  task automatic test_noop();
    send(2'd0, 8'h3C);
    wait_idle();
    send(2'd0, 8'h3C);
    @(negedge clk);
    n_cmp++;
    if (j !== '0 || k !== '0) begin
      n_err++;
      $display("FAIL noop_excite: j=%h k=%h need 00/00", j, k);
    end
    wait_idle();
    send(2'd1, 8'h00);
    wait_idle();
    n_cmp++;
    if (q !== 8'h3C || match !== 1'b1 || flips !== '0) begin
      n_err++;
      $display("FAIL noop_final: q=%h match=%b flips=%0d need 3c/1/0", q, match, flips);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    logic [WIDTH-1:0] ops [4];
    ops[0] = 8'hFF;
    ops[1] = 8'h0F;
    ops[2] = 8'hF0;
    ops[3] = 8'h55;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_op   = 2'd3;
      cmd_data = ops[i];
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ((j | k) === '0) begin
      n_err++;
      $display("FAIL rstmid_excite: j=%h k=%h need nonzero", j, k);
    end
    rst = 1'b1;
    #1;
    sb.delete();
    model_q = '0;
    n_cmp++;
    if (q !== '0 || busy !== 1'b0 || cmd_ready !== 1'b1 || j !== '0 || k !== '0) begin
      n_err++;
      $display("FAIL rstmid_clear: q=%h busy=%b ready=%b j=%h k=%h need 00/0/1/00/00",
               q, busy, cmd_ready, j, k);
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones !== 0 || q !== '0) begin
      n_err++;
      $display("FAIL rstmid_nodone: dones=%0d q=%h need 0/00", dones, q);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      send(2'($urandom_range(0, 3)), WIDTH'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
    end
    wait_idle();
    n_cmp++;
    if (q !== model_q) begin
      n_err++;
      $display("FAIL random_final: q=%h need %h", q, model_q);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_full();
    test_noop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Command-driven controller for a bank of WIDTH JK flip-flop cells.
- The D-from-JK flip-flop derives D behaviour from the JK characteristic; this block works the other way round. It takes desired next-state words and ops, and derives J/K excitation from the JK excitation table.
- Commands are buffered in a small FIFO, applied one per excite cycle, then self-checked against the expected word.
- Sits in the flip-flop library as the reusable JK register-bank front end for counters and sequencers.

Parameters:
- WIDTH, 8, number of JK cells (1..32).
- DEPTH, 4, command FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full; a command transfers when cmd_valid && cmd_ready at a rising edge.
- cmd_op  in  2  0=LOAD, 1=SET, 2=CLR, 3=TOGGLE.
- cmd_data  in  WIDTH  target word (LOAD) or bit mask (SET/CLR/TOGGLE).
- j  out  WIDTH  J excitation currently applied to the cells.
- k  out  WIDTH  K excitation currently applied to the cells.
- q  out  WIDTH  JK bank state.
- qb  out  WIDTH  ~q.
- busy  out  1  state != IDLE or FIFO non-empty.
- done  out  1  one-cycle pulse, command completed.
- match  out  1  valid with done; q equals the expected word.
- flips  out  $clog2(WIDTH+1)  valid with done; popcount of bits changed by the command.

Behaviour:
- Async reset clears:
  - FIFO pointers and count, so cmd_ready=1 after release.
  - FSM to IDLE.
  - q=0 (qb all ones), j=k=0.
  - done=0, match=0, flips=0, busy=0.
- Reset mid-operation discards every queued and in-flight command. No done is produced for them.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full, registered from count.
  - When full, push is refused even if a pop happens in the same cycle.
  - No bypass: a command pushed into an empty FIFO is popped at the next edge at the earliest.
  - Pointers wrap modulo DEPTH.
- FSM, states IDLE, EXCITE, CHECK:
  - IDLE: if FIFO non-empty, pop the head and go to EXCITE. Latch op, data, the current q (q_prev), and expected:
    - LOAD: data.
    - SET: q | data.
    - CLR: q & ~data.
    - TOGGLE: q ^ data.
  - EXCITE, one cycle:
    - Drive j/k. Cells sample them at the closing edge, then go to CHECK.
    - LOAD uses the excitation table, don't-cares resolved to 0: j = ~q & data, k = q & ~data.
    - SET: j = data, k = 0.
    - CLR: j = 0, k = data.
    - TOGGLE: j = k = data.
  - CHECK, one cycle:
    - done=1.
    - match = (q == expected).
    - flips = popcount(q ^ q_prev).
    - Go to IDLE; j=k=0 outside EXCITE.
- Outputs done, match and flips are registered. match and flips are held until the next done.
- Latency:
  - Command accepted at edge n into an idle, empty block.
  - Pop at n+1.
  - q updates at n+2.
  - done is high for the cycle after n+2.
- Throughput: one command per 3 cycles. Back-to-back queued commands pop at the edge that leaves CHECK+IDLE, so there is no bubble beyond IDLE.
- Cells hold (j=k=0) whenever not in EXCITE. q never changes outside EXCITE.
- Zero mask for SET/CLR/TOGGLE is legal: q is unchanged, flips=0, match=1.
- match=0 indicates an excitation/cell fault. It is never expected in correct RTL; the bench flags it.

Decomposition:
- Shared package (jk_bank_pkg):
  - op encoding constants OP_LOAD/OP_SET/OP_CLR/OP_TOGGLE.
  - FSM state enum {IDLE, EXCITE, CHECK}.
  - the excitation function (q, op, data) -> {j, k}.
- Sub-module: jk_cell.
  - 1-bit JK flip-flop with async active-high rst clearing q to 0.
  - Next state: 00 hold, 01 reset, 10 set, 11 toggle.
  - Instantiated WIDTH times via generate.

Test Plan:
- Reset, then LOAD 8'hA5 -> q=A5 two edges after acceptance; j=A5, k=00 during EXCITE; done pulse with match=1, flips=4.
- From q=A5, TOGGLE 8'hFF then CLR 8'h0F queued back-to-back -> q=5A (done, flips=8) then q=50 (done, flips=2); EXCITE of the second has j=00, k=0F.
- Push DEPTH+1 commands with no idle gaps -> cmd_ready drops after DEPTH accepted; the extra command stalls until the first pop; all complete in order with correct q.
- From q=3C, LOAD 8'h3C -> j=k=00, q=3C, match=1, flips=0; SET 8'h00 -> flips=0, match=1.
- Assert rst during EXCITE with 2 commands queued -> q=00 immediately, busy=0, cmd_ready=1, no done pulse after release.
- Random ops and data over 10k commands vs a reference model -> every done has match=1 and the correct flips; j/k are never both nonzero outside EXCITE.
